// File: rtl/mul_share_ctrl.sv
// Round-robin controller time-sharing one external 8x8 unsigned multiplier among NREQ requesters.
// Define MUL_SHARE_CTRL_STATS_EN to add the 16-bit op_count completed-response counter.
module mul_share_ctrl #(
    parameter int NREQ    = 4,
    parameter int MUL_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [8*NREQ-1:0]    req_a,
    input  logic [8*NREQ-1:0]    req_b,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [15:0]          rsp_data,
    output logic [7:0]           mul_in1,
    output logic [7:0]           mul_in2,
    input  logic [15:0]          mul_prod,
    output logic                 busy
`ifdef MUL_SHARE_CTRL_STATS_EN
    ,
    output logic [15:0]          op_count
`endif
);

    localparam int PTR_W = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    state_t           state;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] gnt;
    logic [2:0]       cnt;
    logic [PTR_W-1:0] win;
    logic [PTR_W-1:0] cand;
    logic [PTR_W-1:0] win_next;
    logic             found;

    // First requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = PTR_W'((int'(rr_ptr) + k) % NREQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    assign win_next  = (win == PTR_W'(NREQ - 1)) ? '0 : win + 1'b1;
    assign req_ready = (state == IDLE && found && !rst) ? (NREQ'(1) << win) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            gnt       <= '0;
            cnt       <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            mul_in1   <= '0;
            mul_in2   <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        mul_in1 <= req_a[{win, 3'b000} +: 8];
                        mul_in2 <= req_b[{win, 3'b000} +: 8];
                        gnt     <= win;
                        rr_ptr  <= win_next;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    // Operands stay on mul_in1/mul_in2 while the product settles.
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'(MUL_LAT - 1)) begin
                        rsp_data  <= mul_prod;
                        rsp_valid <= NREQ'(1) << gnt;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready[gnt]) begin
                        rsp_valid <= '0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MUL_SHARE_CTRL_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            op_count <= '0;
        else if (state == RESP && rsp_ready[gnt])
            op_count <= op_count + 16'd1;
    end
`endif

endmodule
